// File: rtl/button_event_pulser.sv
// rtl/button_event_pulser.sv - per-channel press/release/long-hold event pulser (optional BUTTON_AUTOREPEAT_EN)
// Each bit of debounced_signal has its own IDLE/WAIT/HELD FSM with registered single-cycle event outputs.
module button_event_pulser #(
    parameter int width            = 1,
    parameter int hold_cycles      = 25_000_000,
    parameter int repeat_cycles    = 5_000_000,
    parameter int hold_cnt_width   = (hold_cycles > 1) ? $clog2(hold_cycles) : 1,
    parameter int repeat_cnt_width = (repeat_cycles > 1) ? $clog2(repeat_cycles) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] debounced_signal,
    output logic [width-1:0] press_pulse,
    output logic [width-1:0] release_pulse,
    output logic [width-1:0] hold_pulse,
    output logic [width-1:0] long_press
);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_wait = 2'd1,
        st_held = 2'd2
    } state_t;

    localparam logic [hold_cnt_width-1:0] hold_last = hold_cnt_width'(hold_cycles - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [repeat_cnt_width-1:0] repeat_last = repeat_cnt_width'(repeat_cycles - 1);
`endif

    for (genvar i = 0; i < width; i++) begin : g_ch
        state_t                    state;
        logic [hold_cnt_width-1:0] hold_cnt;
        logic                      press_q;
        logic                      release_q;
        logic                      hold_q;
        logic                      long_q;
        logic                      level;
`ifdef BUTTON_AUTOREPEAT_EN
        logic [repeat_cnt_width-1:0] repeat_cnt;
`endif

        assign level = debounced_signal[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= st_idle;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_q    <= 1'b0;
                long_q    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                repeat_cnt <= '0;
`endif
            end else begin
                // Pulses default low so each event lasts exactly one cycle.
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_q    <= 1'b0;
                case (state)
                    st_idle: begin
                        if (level) begin
                            state    <= st_wait;
                            hold_cnt <= '0;
                            press_q  <= 1'b1;
                        end
                    end
                    st_wait: begin
                        if (!level) begin
                            state     <= st_idle;
                            release_q <= 1'b1;
                            hold_cnt  <= '0;
                        end else if (hold_cnt == hold_last) begin
                            state  <= st_held;
                            hold_q <= 1'b1;
                            long_q <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                            repeat_cnt <= '0;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    st_held: begin
                        if (!level) begin
                            state     <= st_idle;
                            release_q <= 1'b1;
                            long_q    <= 1'b0;
                            hold_cnt  <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
                            repeat_cnt <= '0;
`endif
                        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                            if (repeat_cnt == repeat_last) begin
                                repeat_cnt <= '0;
                                press_q    <= 1'b1;
                            end else begin
                                repeat_cnt <= repeat_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        state    <= st_idle;
                        hold_cnt <= '0;
                        long_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign hold_pulse[i]    = hold_q;
        assign long_press[i]    = long_q;
    end

endmodule

// File: tb/tb_button_event_pulser.sv
// tb/tb_button_event_pulser.sv - self-checking bench for button_event_pulser (width=2, hold=8, repeat=3)
module tb_button_event_pulser;

    localparam int W    = 2;
    localparam int HOLD = 8;
    localparam int REP  = 3;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] debounced_signal = '0;
    logic [W-1:0] press_pulse, release_pulse, hold_pulse, long_press;

    int checks = 0;
    int errors = 0;

    button_event_pulser #(.width(W), .hold_cycles(HOLD), .repeat_cycles(REP)) dut (
        .clk(clk), .rst_n(rst_n), .debounced_signal(debounced_signal),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .hold_pulse(hold_pulse), .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Model: outputs follow from the length of the current run of high samples.
    int run [W];
    logic [W-1:0] exp_press, exp_release, exp_hold, exp_long;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < W; c++) run[c] = 0;
            exp_press = '0; exp_release = '0; exp_hold = '0; exp_long = '0;
        end else begin
            for (int c = 0; c < W; c++) begin
                automatic int prev = run[c];
                run[c] = debounced_signal[c] ? prev + 1 : 0;
                exp_press[c]   = (run[c] == 1) ||
                                 (AR && run[c] > HOLD + 1 && ((run[c] - HOLD - 1) % REP) == 0);
                exp_hold[c]    = (run[c] == HOLD + 1);
                exp_release[c] = (run[c] == 0) && (prev > 0);
                exp_long[c]    = (run[c] >= HOLD + 1);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Per-segment event statistics gathered alongside the cycle compare.
    int cyc = 0;
    int n_press [W], n_release [W], n_hold [W], n_long [W];
    int press_cyc0, hold_cyc0, release_cyc0;

    task automatic clear_stats();
        for (int c = 0; c < W; c++) begin
            n_press[c] = 0; n_release[c] = 0; n_hold[c] = 0; n_long[c] = 0;
        end
        press_cyc0 = -1; hold_cyc0 = -1; release_cyc0 = -1;
    endtask

    always @(negedge clk) begin
        cyc++;
        check("press_pulse", press_pulse, exp_press);
        check("release_pulse", release_pulse, exp_release);
        check("hold_pulse", hold_pulse, exp_hold);
        check("long_press", long_press, exp_long);
        for (int c = 0; c < W; c++) begin
            if (press_pulse[c])   n_press[c]++;
            if (release_pulse[c]) n_release[c]++;
            if (hold_pulse[c])    n_hold[c]++;
            if (long_press[c])    n_long[c]++;
        end
        if (press_pulse[0] && press_cyc0 < 0)     press_cyc0 = cyc;
        if (hold_pulse[0] && hold_cyc0 < 0)       hold_cyc0 = cyc;
        if (release_pulse[0] && release_cyc0 < 0) release_cyc0 = cyc;
    end

    task automatic apply(input logic [W-1:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            debounced_signal = v;
        end
    endtask

    initial begin
        clear_stats();
        // 1: reset behaviour
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        apply(2'b00, 2);
        apply(2'b11, 1);
        @(posedge clk); #1;
        check("pre_reset_press", press_pulse, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_press", press_pulse, 2'b00);
        check("async_reset_release", release_pulse, 2'b00);
        check("async_reset_hold", hold_pulse, 2'b00);
        check("async_reset_long", long_press, 2'b00);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_press", press_pulse, 2'b11);
        apply(2'b00, 4);

        // 2: short press
        clear_stats();
        apply(2'b01, 4);
        apply(2'b00, 4);
        check("short_press_count", n_press[0], 1);
        check("short_release_count", n_release[0], 1);
        check("short_hold_count", n_hold[0], 0);
        check("short_press_to_release", release_cyc0 - press_cyc0, 4);

        // 3/4: long press with optional repeats
        clear_stats();
        apply(2'b01, 20);
        apply(2'b00, 4);
        check("long_press_to_hold", hold_cyc0 - press_cyc0, HOLD);
        check("long_hold_count", n_hold[0], 1);
        check("long_release_count", n_release[0], 1);
        check("long_level_cycles", n_long[0], 12);
        check("long_press_count", n_press[0], AR ? 4 : 1);

        // 5: release on the cycle the hold would fire
        clear_stats();
        apply(2'b01, 8);
        apply(2'b00, 4);
        check("tie_hold_count", n_hold[0], 0);
        check("tie_release_count", n_release[0], 1);
        check("tie_long_cycles", n_long[0], 0);

        // 6: channel independence
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            automatic logic b1 = (i == 2 || i == 5 || i == 12);
            apply({b1, 1'b1}, 1);
        end
        apply(2'b00, 4);
        check("indep_ch1_press", n_press[1], 3);
        check("indep_ch1_release", n_release[1], 3);
        check("indep_ch1_hold", n_hold[1], 0);
        check("indep_ch0_press_to_hold", hold_cyc0 - press_cyc0, HOLD);
        check("indep_ch0_release", n_release[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
